// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central stall / flush / forward controller for a 5-stage (F D E M W) pipeline.
//   Sequences the multi-cycle divider in E, holds the pipe while the data memory
//   has not acknowledged an M-stage access, resolves load-use and branch-operand
//   hazards, and produces the operand forwarding selects.
//
// Ports
//   clk, rst                       clock (rising edge), asynchronous active-low reset
//   rsD, rtD, branchD, pc_redirectD D-stage sources, branch compare, taken/jump
//   rsE, rtE, reg_writeE, ...      E-stage sources / destination / load / divide
//   reg_writeM, ..., mem_reqM      M-stage destination / load / pending memory access
//   mem_ok, exceptM                memory completion, exception committed in M
//   reg_writeW, reg_write_enW      W-stage destination
//   stallF..stallW                 inter-stage register holds
//   flushD, flushE, flushM         inter-stage register bubble loads
//   forwardAE/BE                   E operand select: 00 regfile, 01 W, 10 M
//   forwardAD/BD                   D branch comparator takes M result
//   div_start, div_state           divider launch pulse, FSM state (00 RUN 01 BUSY 10 DONE)
module pipe_hazard_ctrl #(
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic       branchD,
    input  logic       pc_redirectD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] reg_writeE,
    input  logic       reg_write_enE,
    input  logic       mem_to_regE,
    input  logic       divE,
    input  logic [4:0] reg_writeM,
    input  logic       reg_write_enM,
    input  logic       mem_to_regM,
    input  logic       mem_reqM,
    input  logic       mem_ok,
    input  logic       exceptM,
    input  logic [4:0] reg_writeW,
    input  logic       reg_write_enW,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       stallM,
    output logic       stallW,
    output logic       flushD,
    output logic       flushE,
    output logic       flushM,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       forwardAD,
    output logic       forwardBD,
    output logic       div_start,
    output logic [1:0] div_state
);

    typedef enum logic [1:0] {
        StRun  = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10
    } div_state_e;

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_raw;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic reg_hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    // ---------------------------------------------------------------------
    // Forwarding (purely combinational, unaffected by reset)
    // ---------------------------------------------------------------------
    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if (reg_write_enM && reg_hit(reg_writeM, rsE)) begin
            forwardAE = 2'b10;
        end else if (reg_write_enW && reg_hit(reg_writeW, rsE)) begin
            forwardAE = 2'b01;
        end
        if (reg_write_enM && reg_hit(reg_writeM, rtE)) begin
            forwardBE = 2'b10;
        end else if (reg_write_enW && reg_hit(reg_writeW, rtE)) begin
            forwardBE = 2'b01;
        end
    end

    // A load in M has no result yet, so it cannot feed the D comparator.
    assign forwardAD = reg_write_enM & ~mem_to_regM & reg_hit(reg_writeM, rsD);
    assign forwardBD = reg_write_enM & ~mem_to_regM & reg_hit(reg_writeM, rtD);

    // ---------------------------------------------------------------------
    // Hazard detection
    // ---------------------------------------------------------------------
    logic mem_wait, div_hold, lw_haz, br_haz;

    assign mem_wait = mem_reqM & ~mem_ok;
    assign div_hold = divE & (state_q != StDone);
    assign lw_haz   = mem_to_regE & reg_write_enE &
                      (reg_hit(reg_writeE, rsD) | reg_hit(reg_writeE, rtD));
    assign br_haz   = branchD &
                      ((reg_write_enE & (reg_hit(reg_writeE, rsD) | reg_hit(reg_writeE, rtD))) |
                       (mem_to_regM   & (reg_hit(reg_writeM, rsD) | reg_hit(reg_writeM, rtD))));

    // Prioritised stall / flush decode; everything idles while in reset.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        stallW = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        if (rst) begin
            if (exceptM) begin
                flushD = 1'b1;
                flushE = 1'b1;
                flushM = 1'b1;
            end else if (mem_wait) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                stallW = 1'b1;
            end else if (div_hold) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                flushM = 1'b1;
            end else if (lw_haz || br_haz) begin
                // Stall beats a redirect: the branch/jump in D is re-evaluated.
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end else if (pc_redirectD) begin
                flushD = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Divider sequencer
    // ---------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        start_raw = 1'b0;
        if (exceptM) begin
            state_d = StRun;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (divE) begin
                        start_raw = 1'b1;
                        cnt_d     = CNT_W'(DIV_CYCLES - 1);
                        state_d   = StBusy;
                    end
                end
                StBusy: begin
                    // Keeps counting through memory waits; the divider is free-running.
                    if (cnt_q == '0) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    // Leave only when the divide actually moves out of E.
                    if (!stallE) begin
                        state_d = StRun;
                    end
                end
                default: begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign div_start = rst & start_raw;
    assign div_state = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vectors, a behavioural
// model compared every cycle, and literal expectations at key points.
module tb_pipe_hazard_ctrl;

    localparam int unsigned DIV_CYCLES = 4;
    localparam int unsigned CNT_W      = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE, reg_writeE, reg_writeM, reg_writeW;
    logic       branchD, pc_redirectD, reg_write_enE, mem_to_regE, divE;
    logic       reg_write_enM, mem_to_regM, mem_reqM, mem_ok, exceptM, reg_write_enW;
    logic       stallF, stallD, stallE, stallM, stallW;
    logic       flushD, flushE, flushM;
    logic [1:0] forwardAE, forwardBE;
    logic       forwardAD, forwardBD;
    logic       div_start;
    logic [1:0] div_state;

    pipe_hazard_ctrl #(
        .DIV_CYCLES(DIV_CYCLES),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rsD          (rsD),
        .rtD          (rtD),
        .branchD      (branchD),
        .pc_redirectD (pc_redirectD),
        .rsE          (rsE),
        .rtE          (rtE),
        .reg_writeE   (reg_writeE),
        .reg_write_enE(reg_write_enE),
        .mem_to_regE  (mem_to_regE),
        .divE         (divE),
        .reg_writeM   (reg_writeM),
        .reg_write_enM(reg_write_enM),
        .mem_to_regM  (mem_to_regM),
        .mem_reqM     (mem_reqM),
        .mem_ok       (mem_ok),
        .exceptM      (exceptM),
        .reg_writeW   (reg_writeW),
        .reg_write_enW(reg_write_enW),
        .stallF       (stallF),
        .stallD       (stallD),
        .stallE       (stallE),
        .stallM       (stallM),
        .stallW       (stallW),
        .flushD       (flushD),
        .flushE       (flushE),
        .flushM       (flushM),
        .forwardAE    (forwardAE),
        .forwardBE    (forwardBE),
        .forwardAD    (forwardAD),
        .forwardBD    (forwardBD),
        .div_start    (div_start),
        .div_state    (div_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model of the divider: busy_left counts remaining BUSY cycles, done marks
    // a finished divide still sitting in E.
    int busy_left = 0;
    bit done      = 1'b0;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    task automatic idle();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        reg_writeE = 0; reg_writeM = 0; reg_writeW = 0;
        branchD = 0; pc_redirectD = 0; reg_write_enE = 0; mem_to_regE = 0; divE = 0;
        reg_write_enM = 0; mem_to_regM = 0; mem_reqM = 0; mem_ok = 0; exceptM = 0;
        reg_write_enW = 0;
    endtask

    // Compare against the model at the falling edge, then advance the model
    // for the coming rising edge; returns 1 time unit after that edge.
    task automatic model_cycle();
        logic [1:0] e_fae, e_fbe, e_ds;
        bit         e_fad, e_fbd, e_start, idle_run, mw, dh, lw, br;
        bit   [4:0] e_st;  // {F,D,E,M,W}
        bit   [2:0] e_fl;  // {D,E,M}
        @(negedge clk);
        if (!rst) begin
            busy_left = 0;
            done      = 1'b0;
        end
        e_fae = (reg_write_enM && hit(reg_writeM, rsE)) ? 2'b10 :
                (reg_write_enW && hit(reg_writeW, rsE)) ? 2'b01 : 2'b00;
        e_fbe = (reg_write_enM && hit(reg_writeM, rtE)) ? 2'b10 :
                (reg_write_enW && hit(reg_writeW, rtE)) ? 2'b01 : 2'b00;
        e_fad = reg_write_enM && !mem_to_regM && hit(reg_writeM, rsD);
        e_fbd = reg_write_enM && !mem_to_regM && hit(reg_writeM, rtD);
        idle_run = (busy_left == 0) && !done;
        e_ds = (busy_left > 0) ? 2'b01 : (done ? 2'b10 : 2'b00);
        mw = mem_reqM && !mem_ok;
        dh = divE && !done;
        lw = mem_to_regE && reg_write_enE && (hit(reg_writeE, rsD) || hit(reg_writeE, rtD));
        br = branchD && ((reg_write_enE && (hit(reg_writeE, rsD) || hit(reg_writeE, rtD))) ||
                         (mem_to_regM && (hit(reg_writeM, rsD) || hit(reg_writeM, rtD))));
        e_st = 0; e_fl = 0; e_start = 0;
        if (rst) begin
            e_start = idle_run && divE && !exceptM;
            if (exceptM)        e_fl = 3'b111;
            else if (mw)        e_st = 5'b11111;
            else if (dh)        begin e_st = 5'b11100; e_fl = 3'b001; end
            else if (lw || br)  begin e_st = 5'b11000; e_fl = 3'b010; end
            else if (pc_redirectD) e_fl = 3'b100;
        end
        chk("m_stalls", {3'b0, stallF, stallD, stallE, stallM, stallW}, {3'b0, e_st});
        chk("m_flushes", {5'b0, flushD, flushE, flushM}, {5'b0, e_fl});
        chk("m_fwdE", {4'b0, forwardAE, forwardBE}, {4'b0, e_fae, e_fbe});
        chk("m_fwdD", {6'b0, forwardAD, forwardBD}, {6'b0, e_fad, e_fbd});
        chk("m_div", {5'b0, div_start, div_state}, {5'b0, e_start, e_ds});
        if (rst) begin
            if (exceptM) begin
                busy_left = 0;
                done      = 1'b0;
            end else if (idle_run) begin
                if (divE) busy_left = DIV_CYCLES;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) done = 1'b1;
            end else if (!e_st[2]) begin
                done = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        // Reset: controls idle even with hazards present; forwards still live.
        rst = 1'b0;
        idle();
        divE = 1; mem_reqM = 1; exceptM = 1; reg_writeM = 5; reg_write_enM = 1; rsE = 5;
        #2;
        chk("rst_stallW", stallW, 0);
        chk("rst_flushD", flushD, 0);
        chk("rst_div_start", div_start, 0);
        chk("rst_div_state", div_state, 0);
        chk("rst_fwdAE", forwardAE, 2'b10);
        model_cycle();
        model_cycle();
        rst = 1'b1;

        // Forward priority and register 0.
        idle();
        reg_writeM = 5; reg_write_enM = 1; reg_writeW = 5; reg_write_enW = 1; rsE = 5; rtE = 5;
        #1;
        chk("fwd_prio_A", forwardAE, 2'b10);
        chk("fwd_prio_B", forwardBE, 2'b10);
        model_cycle();
        rsE = 0; #1; chk("fwd_zero", forwardAE, 2'b00); model_cycle();
        rsE = 6; reg_writeW = 6; #1; chk("fwd_w", forwardAE, 2'b01); model_cycle();
        reg_write_enW = 0; #1; chk("fwd_w_dis", forwardAE, 2'b00); model_cycle();
        idle(); reg_writeM = 0; reg_write_enM = 1; rsE = 0; #1;
        chk("fwd_r0", forwardAE, 2'b00); model_cycle();

        // Load-use with a simultaneous redirect: stall wins.
        idle();
        mem_to_regE = 1; reg_write_enE = 1; reg_writeE = 3; rsD = 3; pc_redirectD = 1; #1;
        chk("lu_stallF", stallF, 1);
        chk("lu_stallE", stallE, 0);
        chk("lu_flushE", flushE, 1);
        chk("lu_flushD", flushD, 0);
        model_cycle();
        idle(); mem_to_regM = 1; reg_write_enM = 1; reg_writeM = 3; rsD = 3; model_cycle();
        idle(); reg_writeW = 3; reg_write_enW = 1; rsE = 3; #1;
        chk("lu_fwdW", forwardAE, 2'b01); model_cycle();

        // Branch operand hazards and D forwarding.
        idle(); branchD = 1; rsD = 7; reg_write_enE = 1; reg_writeE = 7; #1;
        chk("br_E_stallD", stallD, 1); model_cycle();
        idle(); branchD = 1; rtD = 8; mem_to_regM = 1; reg_writeM = 8; reg_write_enM = 1; #1;
        chk("br_M_flushE", flushE, 1);
        chk("br_M_fwdBD", forwardBD, 0);
        model_cycle();
        idle(); branchD = 1; rsD = 9; reg_writeM = 9; reg_write_enM = 1; #1;
        chk("fwdAD", forwardAD, 1);
        chk("fwdAD_nostall", stallF, 0);
        model_cycle();
        idle(); pc_redirectD = 1; #1; chk("redirect_flushD", flushD, 1); model_cycle();

        // Divide: start pulse, 4 BUSY cycles, DONE, then RUN without a new start.
        idle(); divE = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (i == 0) begin
                chk("div_start_pulse", div_start, 1);
                chk("div_c0_stallE", stallE, 1);
            end else if (i < 5) begin
                chk("div_busy_state", div_state, 2'b01);
                chk("div_busy_flushM", flushM, 1);
                chk("div_busy_nostart", div_start, 0);
            end else begin
                chk("div_done_state", div_state, 2'b10);
                chk("div_done_stallE", stallE, 0);
            end
            model_cycle();
        end
        divE = 0; #1;
        chk("div_back_run", div_state, 2'b00);
        chk("div_no_restart", div_start, 0);
        model_cycle();

        // DONE persists across a memory wait; mem_ok ends the wait the same cycle.
        divE = 1;
        repeat (5) model_cycle();
        mem_reqM = 1; mem_ok = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mw_stallF", stallF, 1);
            chk("mw_stallW", stallW, 1);
            chk("mw_done", div_state, 2'b10);
            model_cycle();
        end
        mem_ok = 1; #1;
        chk("mw_ok_stallW", stallW, 0);
        chk("mw_ok_stallE", stallE, 0);
        model_cycle();
        idle(); #1; chk("mw_after_run", div_state, 2'b00); model_cycle();

        // Back-to-back divides.
        divE = 1;
        repeat (12) model_cycle();
        idle(); model_cycle();

        // Exception while BUSY at count 2.
        divE = 1; model_cycle(); model_cycle();
        exceptM = 1; #1;
        chk("exc_flushD", flushD, 1);
        chk("exc_flushM", flushM, 1);
        chk("exc_stallE", stallE, 0);
        model_cycle();
        exceptM = 0; divE = 0; #1;
        chk("exc_run", div_state, 2'b00);
        model_cycle();

        // Asynchronous reset in the middle of BUSY.
        divE = 1; model_cycle(); model_cycle();
        rst = 1'b0; #1;
        chk("arst_state", div_state, 2'b00);
        chk("arst_stallE", stallE, 0);
        chk("arst_flushM", flushM, 0);
        chk("arst_start", div_start, 0);
        model_cycle();
        rst = 1'b1; divE = 0; model_cycle();

        // Request and completion in the same cycle.
        idle(); mem_reqM = 1; mem_ok = 1; #1;
        chk("mem_same_cycle", stallF, 0); model_cycle();

        // Mixed vectors over a small register set.
        for (int i = 0; i < 40; i++) begin
            rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
            rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
            reg_writeE = 5'($urandom_range(0, 3)); reg_writeM = 5'($urandom_range(0, 3));
            reg_writeW = 5'($urandom_range(0, 3));
            branchD = 1'($urandom_range(0, 1)); pc_redirectD = 1'($urandom_range(0, 1));
            reg_write_enE = 1'($urandom_range(0, 1)); mem_to_regE = 1'($urandom_range(0, 1));
            divE = 1'($urandom_range(0, 1)); reg_write_enM = 1'($urandom_range(0, 1));
            mem_to_regM = 1'($urandom_range(0, 1)); mem_reqM = 1'($urandom_range(0, 1));
            mem_ok = 1'($urandom_range(0, 1)); exceptM = ($urandom_range(0, 9) == 0);
            reg_write_enW = 1'($urandom_range(0, 1));
            model_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/forward controller for the 5-stage pipeline (F, D, E, M, W).
- Drives the stall inputs of every inter-stage register (including stallW of the M/W register) and the flush inputs of the D, E and M registers.
- Sequences the multi-cycle divider in E and holds the pipe for the data-memory req/ok handshake in M.
- Resolves load-use and branch-operand hazards, and produces the forwarding selects.

Parameters:
- DIV_CYCLES, 32, cycles from div_start to result valid (≥2).
- CNT_W, 6, width of the divider cycle counter (must hold DIV_CYCLES).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rsD, rtD  in  5  D-stage source registers
- branchD  in  1  branch in D (compared in D)
- pc_redirectD  in  1  branch taken or jump in D
- rsE, rtE  in  5  E-stage source registers
- reg_writeE  in  5  E destination
- reg_write_enE  in  1  E writes regfile
- mem_to_regE  in  1  load in E
- divE  in  1  divide instruction in E
- reg_writeM  in  5  M destination
- reg_write_enM  in  1  M writes regfile
- mem_to_regM  in  1  load in M
- mem_reqM  in  1  load/store in M awaiting memory
- mem_ok  in  1  memory completes M access this cycle
- exceptM  in  1  exception committed in M
- reg_writeW  in  5  W destination
- reg_write_enW  in  1  W writes regfile
- stallF, stallD, stallE, stallM, stallW  out  1  register holds
- flushD, flushE, flushM  out  1  register loads bubble
- forwardAE, forwardBE  out  2  E operand select: 00 regfile, 01 W, 10 M
- forwardAD, forwardBD  out  1  D branch comparator takes M result
- div_start  out  1  one-cycle divider launch pulse
- div_state  out  2  00 RUN, 01 BUSY, 10 DONE

Behaviour:
- Reset (rst=0, async): div_state=RUN, counter=0, div_start=0. While in reset, all stall and flush outputs are 0. Forwards are combinational and unaffected.
- Register-number matches never count when the register number is 0.
- Forward E: forwardAE=10 if reg_write_enM & reg_writeM==rsE. Otherwise it is 01 if reg_write_enW & reg_writeW==rsE. Otherwise it is 00. M has priority over W. forwardBE uses the same rules with rtE.
- Forward D: forwardAD=reg_write_enM & ~mem_to_regM & reg_writeM==rsD. forwardBD uses the same rule with rtD.
- mem_wait = mem_reqM & ~mem_ok.
- div_hold = divE & (state≠DONE).
- lw_haz = mem_to_regE & reg_write_enE & reg_writeE∈{rsD,rtD}.
- br_haz = branchD & one of the following:
  - reg_write_enE & reg_writeE∈{rsD,rtD}, or
  - mem_to_regM & reg_writeM∈{rsD,rtD}.
- Priority, highest first:
  1. exceptM: flushD=flushE=flushM=1, all stalls 0. Divider FSM forced to RUN, counter cleared, no div_start.
  2. mem_wait: stallF..stallW all 1, all flushes 0.
  3. div_hold: stallF=stallD=stallE=1, flushM=1.
  4. lw_haz|br_haz: stallF=stallD=1, flushE=1.
  5. pc_redirectD: flushD=1.
  6. Otherwise: all 0.
- Divider FSM (registered):
  - RUN: if divE & ~exceptM, pulse div_start, load counter=DIV_CYCLES-1, go to BUSY.
  - BUSY: counter decrements every cycle, including during mem_wait. At counter==0 go to DONE.
  - DONE: E released. Return to RUN on the first cycle with stallE=0, i.e. E advances. DONE persists across mem_wait.
  - div_start occurs exactly once per divide instruction. Back-to-back divides get a fresh RUN→BUSY pass.
- Simultaneous events:
  - mem_ok in the same cycle as mem_reqM means no wait.
  - exceptM during BUSY aborts the divide.
  - lw_haz together with pc_redirectD: the stall wins and flushD=0.

Test Plan:
- Load-use: lw $3 in E (mem_to_regE=1, reg_writeE=3), rsD=3 → one cycle with stallF=stallD=1, flushE=1. Next cycle forwardAE=10 is not used; 01 from W two cycles later.
- Forward priority: reg_writeM=reg_writeW=5, both enabled, rsE=5 → forwardAE=10. rsE=0 with the same writes → 00.
- Divide, DIV_CYCLES=4: divE rises → div_start for 1 cycle, then stallE=1 and flushM=1 for 4 cycles, then div_state=DONE and stallE=0. RUN follows the next cycle, with no second div_start.
- Memory wait: mem_reqM=1, mem_ok=0 for 3 cycles → all five stalls 1 for 3 cycles. Then mem_ok=1 → all stalls 0 the same cycle.
- Exception mid-divide: exceptM at BUSY count 2 → flushD/E/M=1 and div_state=RUN next cycle.
- Reset mid-BUSY: rst low asynchronously → div_state=00, div_start=0, all stalls/flushes 0 immediately.
